// File: rtl/row_mean_stream.sv
// Streaming per-row mean: accumulates SIZE_B signed samples per row, then divides the row sum
// by SIZE_B with a fixed-latency restoring divider before presenting the mean downstream.
module row_mean_stream #(
    parameter int unsigned SIZE_A = 8,
    parameter int unsigned SIZE_B = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROUND  = 0,
    localparam int unsigned RW    = (SIZE_A > 1) ? $clog2(SIZE_A) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RW-1:0]     out_row,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned ACC_W = DATA_W + $clog2(SIZE_B) + 1;
    localparam int unsigned CW    = $clog2(SIZE_B);
    localparam int unsigned NW    = $clog2(ACC_W);

    localparam logic [ACC_W-1:0] DIVISOR = ACC_W'(SIZE_B);
    localparam logic [ACC_W-1:0] RND     = ACC_W'((ROUND != 0) ? (SIZE_B / 2) : 0);

    typedef enum logic [1:0] {StAcc, StDiv, StOut} state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ACC_W-1:0]  dvd_q, dvd_d;
    logic [ACC_W-2:0]  rem_q, rem_d;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [ACC_W-1:0]  sample_ext;
    logic [ACC_W-1:0]  sum_add;
    logic [ACC_W-1:0]  sum_abs;
    logic [ACC_W-1:0]  trial;
    logic              qbit;
    logic [ACC_W-1:0]  quot;
    logic [DATA_W-1:0] q_trunc;

    assign sample_ext = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    assign sum_add    = sum_q + sample_ext;
    assign sum_abs    = sum_add[ACC_W-1] ? (~sum_add + ACC_W'(1)) : sum_add;

    // The remainder never reaches SIZE_B, so one shifted-in dividend bit fits in ACC_W bits.
    assign trial   = {rem_q, dvd_q[ACC_W-1]};
    assign qbit    = (trial >= DIVISOR);
    assign quot    = {dvd_q[ACC_W-2:0], qbit};
    assign q_trunc = quot[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        col_d      = col_q;
        row_d      = row_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_d = sum_add;
                    if (col_q == CW'(SIZE_B - 1)) begin
                        // Load the divider straight from the completed sum to save a cycle.
                        state_d = StDiv;
                        dvd_d   = sum_abs + RND;
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_d   = sum_add[ACC_W-1];
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDiv: begin
                rem_d = qbit ? (trial[ACC_W-2:0] - DIVISOR[ACC_W-2:0]) : trial[ACC_W-2:0];
                dvd_d = quot;
                cnt_d = cnt_q + NW'(1);
                if (cnt_q == NW'(ACC_W - 1)) begin
                    state_d    = StOut;
                    out_data_d = neg_q ? (-q_trunc) : q_trunc;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StAcc;
                    sum_d   = '0;
                    col_d   = '0;
                    row_d   = (row_q == RW'(SIZE_A - 1)) ? '0 : row_q + RW'(1);
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StAcc;
            sum_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            col_q      <= col_d;
            row_q      <= row_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;
    assign out_row  = row_q;
    assign out_last = (row_q == RW'(SIZE_A - 1));
    assign busy     = !((state_q == StAcc) && (col_q == '0) && (row_q == '0));

endmodule

// File: tb/tb_row_mean_stream.sv
// Directed bench for row_mean_stream: a truncating and a rounding instance share all inputs,
// so every scenario checks both rounding modes at once.
module tb_row_mean_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic        out_last0, out_last1, busy0, busy1;
    logic [15:0] out_data0, out_data1;
    logic [0:0]  out_row0, out_row1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    row_mean_stream #(.SIZE_A(2), .SIZE_B(3), .DATA_W(16), .ROUND(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_row(out_row0), .out_last(out_last0), .busy(busy0)
    );

    row_mean_stream #(.SIZE_A(2), .SIZE_B(3), .DATA_W(16), .ROUND(1)) u_round (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_row(out_row1), .out_last(out_last1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Leaves in_valid high so consecutive calls stream without bubbles.
    task automatic send(input logic [15:0] d, input int gap);
        int b = 0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready0 && b < 100) begin
            tick();
            b++;
        end
        tick();
    endtask

    task automatic wait_mean(output logic ok, output logic [15:0] d0, output logic [15:0] d1,
                             output logic [0:0] r, output logic l, input int hold);
        int b = 0;
        in_valid = 1'b0;
        while (!out_valid0 && b < 100) begin
            tick();
            b++;
        end
        ok = out_valid0 && out_valid1;
        d0 = out_data0;
        d1 = out_data1;
        r  = out_row0;
        l  = out_last0;
        for (int i = 0; i < hold; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 16'd5;
        rst_n    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if ({out_valid0, out_valid1} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 00", {out_valid0, out_valid1});
        end
        vectors++;
        if ({out_data0, out_data1} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out_data: got %0d/%0d expected 0/0", out_data0, out_data1);
        end
        vectors++;
        if ({out_row0, out_last0, out_row1, out_last1} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_row_last: got %b expected 0000",
                     {out_row0, out_last0, out_row1, out_last1});
        end
        vectors++;
        if ({busy0, busy1, in_ready0, in_ready1} !== 4'b0011) begin
            miscompares++;
            $display("FAIL reset_busy_ready: got %b expected 0011",
                     {busy0, busy1, in_ready0, in_ready1});
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        vectors++;
        if ({out_valid0, busy0, in_ready0, out_data0} !== {3'b001, 16'd0}) begin
            miscompares++;
            $display("FAIL post_reset: got valid=%b busy=%b ready=%b data=%0d expected 0 0 1 0",
                     out_valid0, busy0, in_ready0, out_data0);
        end
        send(16'd1, 0);
        in_valid = 1'b0;
        vectors++;
        if ({busy0, busy1} !== 2'b11) begin
            miscompares++;
            $display("FAIL busy_after_sample: got %b expected 11", {busy0, busy1});
        end
    endtask

    task automatic test_basic();
        int smp[6] = '{1, 2, 3, -7, -7, -6};
        int e0[2]  = '{2, -6};
        int e1[2]  = '{2, -7};
        logic ok, l;
        logic [15:0] d0, d1;
        logic [0:0] r;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) send(16'(smp[3*k+i]), 0);
            wait_mean(ok, d0, d1, r, l, 0);
            vectors++;
            if ({ok, d0, d1, r, l} !== {1'b1, 16'(e0[k]), 16'(e1[k]), 1'(k % 2), 1'(k % 2)}) begin
                miscompares++;
                $display("FAIL basic[%0d]: got valid=%b d0=%0d d1=%0d row=%0d last=%b, expected valid=1 d0=%0d d1=%0d row=%0d last=%0d",
                         k, ok, $signed(d0), $signed(d1), r, l, e0[k], e1[k], k % 2, k % 2);
            end
        end
    endtask

    task automatic test_round();
        int smp[6] = '{1, 1, 2, 1, 2, 2};
        int e0[2]  = '{1, 1};
        int e1[2]  = '{1, 2};
        logic ok, l;
        logic [15:0] d0, d1;
        logic [0:0] r;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) send(16'(smp[3*k+i]), 0);
            wait_mean(ok, d0, d1, r, l, 0);
            vectors++;
            if ({ok, d0, d1, r, l} !== {1'b1, 16'(e0[k]), 16'(e1[k]), 1'(k % 2), 1'(k % 2)}) begin
                miscompares++;
                $display("FAIL round[%0d]: got valid=%b d0=%0d d1=%0d row=%0d last=%b, expected valid=1 d0=%0d d1=%0d row=%0d last=%0d",
                         k, ok, $signed(d0), $signed(d1), r, l, e0[k], e1[k], k % 2, k % 2);
            end
        end
    endtask

    task automatic test_latency();
        int   cycles  = 0;
        logic quiet   = 1'b1;
        logic held_ok;
        do_reset();
        send(16'd4, 0);
        send(16'd5, 0);
        send(16'd6, 0);
        in_valid = 1'b0;
        while (!out_valid0 && cycles < 50) begin
            if (in_ready0 || in_ready1 || !busy0 || out_valid1) quiet = 1'b0;
            tick();
            cycles++;
        end
        vectors++;
        if (cycles !== 19 || out_valid1 !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles (valid1=%b) expected 19 cycles (valid1=1)",
                     cycles, out_valid1);
        end
        vectors++;
        if (quiet !== 1'b1) begin
            miscompares++;
            $display("FAIL div_quiet: got %b expected 1", quiet);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            held_ok = (out_valid0 === 1'b1) && (out_data0 === 16'd5) && (out_row0 === 1'b0)
                      && (in_ready0 === 1'b0) && (out_data1 === 16'd5);
            vectors++;
            if (!held_ok) begin
                miscompares++;
                $display("FAIL hold[%0d]: got valid=%b d0=%0d d1=%0d row=%0d ready=%b expected 1 5 5 0 0",
                         i, out_valid0, out_data0, out_data1, out_row0, in_ready0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if ({out_valid0, in_ready0, out_row0} !== 3'b011) begin
            miscompares++;
            $display("FAIL after_transfer: got valid=%b ready=%b row=%0d expected 0 1 1",
                     out_valid0, in_ready0, out_row0);
        end
    endtask

    task automatic test_extremes();
        int smp[9] = '{32767, 32767, 32767, -32768, -32768, -32768, 32767, -32768, 0};
        int e0[3]  = '{32767, -32768, 0};
        int e1[3]  = '{32767, -32768, 0};
        logic ok, l;
        logic [15:0] d0, d1;
        logic [0:0] r;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) send(16'(smp[3*k+i]), 0);
            wait_mean(ok, d0, d1, r, l, 0);
            vectors++;
            if ({ok, d0, d1, r, l} !== {1'b1, 16'(e0[k]), 16'(e1[k]), 1'(k % 2), 1'(k % 2)}) begin
                miscompares++;
                $display("FAIL extremes[%0d]: got valid=%b d0=%0d d1=%0d row=%0d last=%b, expected valid=1 d0=%0d d1=%0d row=%0d last=%0d",
                         k, ok, $signed(d0), $signed(d1), r, l, e0[k], e1[k], k % 2, k % 2);
            end
        end
    endtask

    task automatic test_gaps();
        int smp[12] = '{1, 2, 3, -7, -7, -6, 1, 1, 2, 1, 2, 2};
        int e0[4]   = '{2, -6, 1, 1};
        int e1[4]   = '{2, -7, 1, 2};
        logic ok, l;
        logic [15:0] d0, d1;
        logic [0:0] r;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) send(16'(smp[3*k+i]), $urandom_range(0, 3));
            wait_mean(ok, d0, d1, r, l, $urandom_range(0, 2));
            vectors++;
            if ({ok, d0, d1, r, l} !== {1'b1, 16'(e0[k]), 16'(e1[k]), 1'(k % 2), 1'(k % 2)}) begin
                miscompares++;
                $display("FAIL gaps[%0d]: got valid=%b d0=%0d d1=%0d row=%0d last=%b, expected valid=1 d0=%0d d1=%0d row=%0d last=%0d",
                         k, ok, $signed(d0), $signed(d1), r, l, e0[k], e1[k], k % 2, k % 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int smp[12] = '{1, 2, 3, -7, -7, -6, 1, 1, 2, 1, 2, 2};
        int e0[4]   = '{2, -6, 1, 1};
        int e1[4]   = '{2, -7, 1, 2};
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) send(16'(smp[i]), 0);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    int b = 0;
                    while (!out_valid0 && b < 100) begin
                        tick();
                        b++;
                    end
                    vectors++;
                    if ({out_valid0, out_valid1, out_data0, out_data1, out_row0, out_last0} !==
                        {2'b11, 16'(e0[k]), 16'(e1[k]), 1'(k % 2), 1'(k % 2)}) begin
                        miscompares++;
                        $display("FAIL b2b[%0d]: got valid=%b%b d0=%0d d1=%0d row=%0d last=%b, expected valid=11 d0=%0d d1=%0d row=%0d last=%0d",
                                 k, out_valid0, out_valid1, $signed(out_data0), $signed(out_data1),
                                 out_row0, out_last0, e0[k], e1[k], k % 2, k % 2);
                    end
                    tick();
                end
            end
        join
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic ok, l;
        logic [15:0] d0, d1;
        logic [0:0] r;
        logic saw_valid = 1'b0;
        do_reset();
        send(16'd100, 0);
        send(16'd100, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({busy0, in_ready0, out_valid0} !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_row_reset: got busy=%b ready=%b valid=%b expected 0 1 0",
                     busy0, in_ready0, out_valid0);
        end
        send(16'd7, 0);
        send(16'd8, 0);
        send(16'd9, 0);
        wait_mean(ok, d0, d1, r, l, 0);
        vectors++;
        if ({ok, d0, d1, r, l} !== {1'b1, 16'd8, 16'd8, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_row_mean: got valid=%b d0=%0d d1=%0d row=%0d last=%b expected 1 8 8 0 0",
                     ok, $signed(d0), $signed(d1), r, l);
        end
        send(16'd50, 0);
        send(16'd50, 0);
        send(16'd50, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({out_data0, out_row0, busy0, in_ready0} !== {16'd0, 3'b001}) begin
            miscompares++;
            $display("FAIL mid_div_reset: got data=%0d row=%0d busy=%b ready=%b expected 0 0 0 1",
                     out_data0, out_row0, busy0, in_ready0);
        end
        for (int i = 0; i < 30; i++) begin
            if (out_valid0 || out_valid1) saw_valid = 1'b1;
            tick();
        end
        vectors++;
        if (saw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_valid_after_reset: got %b expected 0", saw_valid);
        end
        send(16'd1, 0);
        send(16'd2, 0);
        send(16'd3, 0);
        wait_mean(ok, d0, d1, r, l, 0);
        vectors++;
        if ({ok, d0, d1, r, l} !== {1'b1, 16'd2, 16'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL post_div_reset_mean: got valid=%b d0=%0d d1=%0d row=%0d last=%b expected 1 2 2 0 0",
                     ok, $signed(d0), $signed(d1), r, l);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_round();
        test_latency();
        test_extremes();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/row_mean_stream.md
ROW_MEAN_STREAM -- requirements
Module: row_mean_stream

Interface
REQ-001 The block SHALL take parameter SIZE_A, default 8: rows (channels) per matrix, >= 1.
REQ-002 The block SHALL take parameter SIZE_B, default 8: samples per row, >= 2; not required to equal SIZE_A.
REQ-003 The block SHALL take parameter DATA_W, default 32: signed two's-complement sample and mean width.
REQ-004 The block SHALL take parameter ROUND, default 0: 0 = truncate toward zero, 1 = round half away from zero.
REQ-005 The block SHALL derive localparams ACC_W = DATA_W + clog2(SIZE_B) + 1 and RW = max(1, clog2(SIZE_A)).
REQ-006 The block SHALL have a single clock and a synchronous, active-low reset, with ports listed clock first, then reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample
- in_data  in  DATA_W  signed sample, row-major order
- out_valid  out  1  mean present
- out_ready  in  1  downstream accepts mean
- out_data  out  DATA_W  signed row mean
- out_row  out  RW  row index of out_data
- out_last  out  1  out_data is row SIZE_A-1
- busy  out  1  high in any state except ACC with zero samples accepted in the current matrix

Function
REQ-007 The block SHALL implement FSM states ACC, DIV and OUT.
REQ-008 A transfer SHALL occur on a rising edge with valid and ready both high; a sample SHALL be accepted only on an input transfer.
REQ-009 ACC: in_ready=1, out_valid=0; each accepted sample is sign-extended to ACC_W and added to the row sum.
REQ-010 A column counter SHALL count 0..SIZE_B-1; the accepted sample with column SIZE_B-1 completes the row and moves the FSM to DIV.
REQ-011 Cycles with in_valid=0 SHALL change no state; gaps of any length SHALL be tolerated.
REQ-012 DIV: in_ready=0, out_valid=0; a sequential restoring divider divides |sum| (+ SIZE_B/2 when ROUND=1) by SIZE_B, one quotient bit per cycle, for exactly ACC_W cycles.
REQ-013 The quotient SHALL be negated when sum < 0, truncated to DATA_W and registered into out_data.
REQ-014 The result SHALL always fit DATA_W; no saturation logic is needed.
REQ-015 The divider SHALL run for the full ACC_W cycles for every SIZE_B, power of two or not; latency SHALL be fixed.
REQ-016 Latency: if the row-completing sample transfers on edge k, out_valid SHALL first be high in the cycle after edge k+ACC_W.
REQ-017 OUT: out_valid=1, in_ready=0.
REQ-018 out_data, out_row and out_last SHALL hold stable until the output transfer.
REQ-019 out_row SHALL be the row counter; out_last SHALL be 1 iff out_row = SIZE_A-1.
REQ-020 On the output transfer the sum and column counter SHALL clear and the FSM SHALL return to ACC.
REQ-021 The row counter SHALL increment on each output transfer and wrap from SIZE_A-1 to 0 for the next matrix.
REQ-022 in_ready SHALL be 0 in the cycle an output transfer occurs; the first sample of the next row SHALL be accepted no earlier than the following cycle.

Reset
REQ-023 While rst_n=0 at a rising edge, the block SHALL set FSM=ACC and clear the sum, column counter, row counter and divider registers.
REQ-024 Outputs during and after reset SHALL be: out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, in_ready=1.
REQ-025 Reset asserted mid-row, mid-DIV or in OUT SHALL discard all partial work; the next accepted sample is row 0, column 0.

Verification
REQ-026 The bench SHALL cover the following directed scenarios, all with SIZE_A=2, SIZE_B=3, DATA_W=16.
- ROUND=0: samples 1,2,3,-7,-7,-6 -> means 2 (row 0, out_last=0), then -6 (row 1, out_last=1).
- ROUND=1, same samples -> 2 then -7; also 1,1,2 -> 1 and 1,2,2 -> 2.
- Latency: full ACC_W=19 DIV cycles between row-completing sample and out_valid; out_ready=0 for 5 cycles -> out_valid, out_data and out_row held, in_ready=0 throughout.
- Extremes: 32767 x3 -> 32767; -32768 x3 -> -32768; 32767,-32768,0 -> 0 (ROUND=0 and ROUND=1).
- in_valid toggled randomly, plus back-to-back matrices -> results identical to gap-free runs; out_row wraps 1 -> 0.
- rst_n low for 1 cycle after 2 samples of row 0, and again during DIV -> no out_valid; the next 3 samples yield a row-0 mean computed only from post-reset data.
